// File: rtl/timer_pkg.sv
// Shared register map, CTRL field positions, mode codes and channel state type.
package timer_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM       = 3;
    localparam int unsigned CTRL_PSC_LSB  = 8;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS, prescaler, FSM and sticky PEND.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PSC_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [1:0]          reg_sel,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata_c,
    output logic                irq_c
);

    ch_state_e        state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;

    // Not every data bit maps onto a field for every parameter choice.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    // Bus writes take the cycle; otherwise the FSM and prescaler advance.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        psc_d    = psc_q;
        pcnt_d   = pcnt_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        if (wr_en) begin
            case (reg_sel)
                REG_CTRL: begin
                    en_d    = wdata[CTRL_EN];
                    mode_d  = wdata[CTRL_MODE_LSB +: 2];
                    im_d    = wdata[CTRL_IM];
                    psc_d   = wdata[CTRL_PSC_LSB +: PSC_W];
                    state_d = IDLE;
                end
                REG_PRESET: preset_d = wdata[CNT_W-1:0];
                REG_STATUS: if (wdata[0]) pend_d = 1'b0;
                default: ;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_q && (mode_q == MODE_ONESHOT || mode_q == MODE_RELOAD))
                        state_d = LOAD;
                end
                LOAD: begin
                    count_d = (preset_q == '0) ? CNT_W'(1) : preset_q;
                    pcnt_d  = '0;
                    state_d = CNT;
                end
                CNT: begin
                    if (!en_q) begin
                        state_d = IDLE;
                    end else if (pcnt_q == psc_q) begin
                        pcnt_d = '0;
                        if (count_q > CNT_W'(1)) begin
                            count_d = count_q - CNT_W'(1);
                        end else begin
                            pend_d = 1'b1;
                            if (mode_q == MODE_RELOAD) begin
                                state_d = LOAD;
                            end else begin
                                count_d = '0;
                                en_d    = 1'b0;
                                state_d = IDLE;
                            end
                        end
                    end else begin
                        pcnt_d = pcnt_q + PSC_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'd0;
            im_q     <= 1'b0;
            psc_q    <= '0;
            pcnt_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            psc_q    <= psc_d;
            pcnt_q   <= pcnt_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
        end
    end

    // Register read mux; unused bits read as zero.
    always_comb begin
        rdata_c = '0;
        case (reg_sel)
            REG_CTRL: begin
                rdata_c[CTRL_EN]                  = en_q;
                rdata_c[CTRL_MODE_LSB +: 2]       = mode_q;
                rdata_c[CTRL_IM]                  = im_q;
                rdata_c[CTRL_PSC_LSB +: PSC_W]    = psc_q;
            end
            REG_PRESET: rdata_c = DATA_W'(preset_q);
            REG_COUNT:  rdata_c = DATA_W'(count_q);
            default:    rdata_c[0] = pend_q;
        endcase
    end

    assign irq_c = pend_q & im_q;

endmodule

// File: rtl/timer_multi.sv
// N_CH-channel bus timer: address decode, read mux and IRQ combine.
module timer_multi
    import timer_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned PSC_W = 8,
    parameter int unsigned AW    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW+1:0]     addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic [N_CH-1:0]   irq,
    output logic              irq_any
);

    localparam int unsigned N_SLOT = 1 << AW;

    logic [AW-1:0] ch_sel;
    logic [1:0]    reg_sel;
    logic [31:0]   rd_slot [N_SLOT];

    assign ch_sel  = addr[AW+1:2];
    assign reg_sel = addr[1:0];

    // One channel per populated slot; empty slots read zero and ignore writes.
    for (genvar g = 0; g < int'(N_SLOT); g++) begin : g_slot
        if (g < int'(N_CH)) begin : g_ch
            logic wr_en;
            assign wr_en = we && (ch_sel == AW'(g));
            timer_channel #(
                .CNT_W (CNT_W),
                .PSC_W (PSC_W)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .wr_en   (wr_en),
                .reg_sel (reg_sel),
                .wdata   (data_in),
                .rdata_c (rd_slot[g]),
                .irq_c   (irq[g])
            );
        end else begin : g_empty
            assign rd_slot[g] = '0;
        end
    end

    assign data_out = rd_slot[ch_sel];
    assign irq_any  = |irq;

endmodule
